pwm_deadtime: RTL and testbench

Per-channel dead-time inserter and fault gate, placed directly downstream of the GPIO PWM generator. Consumes the raw PWM vector and produces complementary high-side/low-side drive pairs. Both sides of a pair are never on together, and switching between them is separated by a programmable number of off cycles. A latched fault input forces every drive low until software clears it.

---
 rtl/pwm_deadtime.sv | 138 +++++++++++++
 tb/tb_pwm_deadtime.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Dead-time inserter and fault gate for complementary PWM drive pairs.
// One Moore FSM per channel; drive outputs and the fault flag are registered.
module pwm_deadtime #(
    parameter int CHANNELS = 3,
    parameter int DT_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] pwm_i,
    input  logic [CHANNELS-1:0] enable_i,
    input  logic [DT_WIDTH-1:0] deadtime_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic [CHANNELS-1:0] hs_o,
    output logic [CHANNELS-1:0] ls_o,
    output logic [CHANNELS-1:0] dead_o,
    output logic                fault_o
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        DEAD_HS = 3'd1,
        HS_ON   = 3'd2,
        DEAD_LS = 3'd3,
        LS_ON   = 3'd4
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_d   [CHANNELS];

    logic [CHANNELS-1:0] hs_d;
    logic [CHANNELS-1:0] ls_d;
    logic [CHANNELS-1:0] dead_d;
    logic                fault_d;
    logic                hold_off;
    logic                dt_zero;

    // A fault request or a still-latched fault keeps every pair off
    assign hold_off = fault_i | fault_o;
    assign dt_zero  = (deadtime_i == '0);
    assign fault_d  = fault_i | (fault_o & ~fault_clr_i);

    // State, counter, output and fault registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= OFF;
                cnt_q[c]   <= '0;
            end
            hs_o    <= '0;
            ls_o    <= '0;
            dead_o  <= '0;
            fault_o <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            hs_o    <= hs_d;
            ls_o    <= ls_d;
            dead_o  <= dead_d;
            fault_o <= fault_d;
        end
    end

    // Next-state and dead-time counter per channel
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            if (hold_off || !enable_i[c]) begin
                state_d[c] = OFF;
                cnt_d[c]   = '0;
            end else begin
                unique case (state_q[c])
                    OFF: begin
                        cnt_d[c] = deadtime_i;
                        if (pwm_i[c])
                            state_d[c] = dt_zero ? HS_ON : DEAD_HS;
                        else
                            state_d[c] = dt_zero ? LS_ON : DEAD_LS;
                    end
                    HS_ON: begin
                        if (!pwm_i[c]) begin
                            cnt_d[c]   = deadtime_i;
                            state_d[c] = dt_zero ? LS_ON : DEAD_LS;
                        end
                    end
                    LS_ON: begin
                        if (pwm_i[c]) begin
                            cnt_d[c]   = deadtime_i;
                            state_d[c] = dt_zero ? HS_ON : DEAD_HS;
                        end
                    end
                    DEAD_HS: begin
                        if (!pwm_i[c]) begin
                            state_d[c] = DEAD_LS;
                            cnt_d[c]   = deadtime_i;
                        end else if (cnt_q[c] <= DT_WIDTH'(1)) begin
                            state_d[c] = HS_ON;
                        end else begin
                            cnt_d[c] = cnt_q[c] - DT_WIDTH'(1);
                        end
                    end
                    DEAD_LS: begin
                        if (pwm_i[c]) begin
                            state_d[c] = DEAD_HS;
                            cnt_d[c]   = deadtime_i;
                        end else if (cnt_q[c] <= DT_WIDTH'(1)) begin
                            state_d[c] = LS_ON;
                        end else begin
                            cnt_d[c] = cnt_q[c] - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[c] = OFF;
                        cnt_d[c]   = '0;
                    end
                endcase
            end
        end
    end

    // Moore outputs decoded from the next state, registered above
    always_comb begin
        hs_d   = '0;
        ls_d   = '0;
        dead_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hs_d[c]   = (state_d[c] == HS_ON);
            ls_d[c]   = (state_d[c] == LS_ON);
            dead_d[c] = (state_d[c] == DEAD_HS) || (state_d[c] == DEAD_LS);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and randomized checks for pwm_deadtime.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_deadtime;

    localparam int CH = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pwm;
    logic [CH-1:0] en;
    logic [DW-1:0] dt;
    logic          flt;
    logic          clr;
    logic [CH-1:0] hs;
    logic [CH-1:0] ls;
    logic [CH-1:0] dead;
    logic          fo;

    int total = 0;
    int bad   = 0;

    logic [CH-1:0] ph [0:31];

    pwm_deadtime #(.CHANNELS(CH), .DT_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pwm_i      (pwm),
        .enable_i   (en),
        .deadtime_i (dt),
        .fault_i    (flt),
        .fault_clr_i(clr),
        .hs_o       (hs),
        .ls_o       (ls),
        .dead_o     (dead),
        .fault_o    (fo)
    );

    always #5 clk = ~clk;

    // pwm value seen at each of the last 32 rising edges (ph[0] = latest)
    always @(posedge clk) begin
        for (int i = 31; i > 0; i--) ph[i] <= ph[i-1];
        ph[0] <= pwm;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pwm = 3'b111; en = 3'b111; dt = 16'd4;
        flt = 1'b0; clr = 1'b0;
        tick(); tick();
        total++;
        if (hs !== 3'b000) begin bad++; $display("FAIL reset_hs got=%b exp=000", hs); end
        total++;
        if (ls !== 3'b000) begin bad++; $display("FAIL reset_ls got=%b exp=000", ls); end
        total++;
        if (dead !== 3'b000) begin bad++; $display("FAIL reset_dead got=%b exp=000", dead); end
        total++;
        if (fo !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fo); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (dead !== 3'b111 || hs !== 3'b000 || ls !== 3'b000) begin
                bad++;
                $display("FAIL reset_exit_dead cyc=%0d got hs=%b ls=%b dead=%b exp 000/000/111",
                         i, hs, ls, dead);
            end
        end
        tick();
        total++;
        if (hs !== 3'b111 || dead !== 3'b000) begin
            bad++;
            $display("FAIL reset_exit_hs got hs=%b dead=%b exp 111/000", hs, dead);
        end
    endtask

    task automatic test_deadtime();
        dt = 16'd3;
        pwm = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({hs[0], ls[0], dead[0]} !== 3'b001) begin
                bad++;
                $display("FAIL dt3_fall cyc=%0d got hs/ls/dead=%b exp 001", i, {hs[0], ls[0], dead[0]});
            end
        end
        tick();
        total++;
        if (hs !== 3'b110 || ls !== 3'b001 || dead !== 3'b000) begin
            bad++;
            $display("FAIL dt3_ls_on got hs=%b ls=%b dead=%b exp 110/001/000", hs, ls, dead);
        end
        pwm = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({hs[0], ls[0], dead[0]} !== 3'b001) begin
                bad++;
                $display("FAIL dt3_rise cyc=%0d got hs/ls/dead=%b exp 001", i, {hs[0], ls[0], dead[0]});
            end
        end
        tick();
        total++;
        if (hs !== 3'b111 || ls !== 3'b000) begin
            bad++;
            $display("FAIL dt3_hs_on got hs=%b ls=%b exp 111/000", hs, ls);
        end
    endtask

    task automatic test_dt0();
        dt = 16'd0;
        for (int i = 0; i < 25; i++) begin
            if (i % 5 == 0) pwm[0] = ~pwm[0];
            tick();
            total++;
            if ({hs[0], ls[0]} !== {pwm[0], ~pwm[0]} || dead !== 3'b000) begin
                bad++;
                $display("FAIL dt0_follow cyc=%0d got hs=%b ls=%b dead=%b pwm0=%b",
                         i, hs[0], ls[0], dead, pwm[0]);
            end
        end
    endtask

    task automatic test_glitch();
        dt = 16'd8;
        pwm[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({hs[0], ls[0], dead[0]} !== 3'b001) begin
                bad++;
                $display("FAIL glitch_high cyc=%0d got hs/ls/dead=%b exp 001", i, {hs[0], ls[0], dead[0]});
            end
        end
        pwm[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({hs[0], ls[0], dead[0]} !== 3'b001) begin
                bad++;
                $display("FAIL glitch_restart cyc=%0d got hs/ls/dead=%b exp 001", i, {hs[0], ls[0], dead[0]});
            end
        end
        tick();
        total++;
        if ({hs[0], ls[0], dead[0]} !== 3'b010) begin
            bad++;
            $display("FAIL glitch_ls_back got hs/ls/dead=%b exp 010", {hs[0], ls[0], dead[0]});
        end
    endtask

    task automatic test_dt_sample();
        dt = 16'd5;
        pwm[0] = 1'b1;
        tick();
        dt = 16'd1;
        for (int i = 1; i < 5; i++) begin
            tick();
            total++;
            if ({hs[0], ls[0], dead[0]} !== 3'b001) begin
                bad++;
                $display("FAIL dt_sampled cyc=%0d got hs/ls/dead=%b exp 001", i, {hs[0], ls[0], dead[0]});
            end
        end
        tick();
        total++;
        if ({hs[0], ls[0], dead[0]} !== 3'b100) begin
            bad++;
            $display("FAIL dt_sampled_on got hs/ls/dead=%b exp 100", {hs[0], ls[0], dead[0]});
        end
    endtask

    task automatic test_fault();
        dt = 16'd2;
        total++;
        if (hs !== 3'b111) begin bad++; $display("FAIL fault_pre got hs=%b exp 111", hs); end
        flt = 1'b1;
        tick();
        total++;
        if (hs !== 3'b000 || ls !== 3'b000 || dead !== 3'b000 || fo !== 1'b1) begin
            bad++;
            $display("FAIL fault_entry got hs=%b ls=%b dead=%b fault=%b exp 000/000/000/1", hs, ls, dead, fo);
        end
        clr = 1'b1;
        tick();
        total++;
        if (fo !== 1'b1 || hs !== 3'b000) begin
            bad++;
            $display("FAIL fault_clr_blocked got fault=%b hs=%b exp 1/000", fo, hs);
        end
        clr = 1'b0; flt = 1'b0;
        tick();
        total++;
        if (fo !== 1'b1 || hs !== 3'b000 || dead !== 3'b000) begin
            bad++;
            $display("FAIL fault_latched got fault=%b hs=%b dead=%b exp 1/000/000", fo, hs, dead);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (fo !== 1'b0 || hs !== 3'b000 || dead !== 3'b000) begin
            bad++;
            $display("FAIL fault_clear got fault=%b hs=%b dead=%b exp 0/000/000", fo, hs, dead);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (dead !== 3'b111 || hs !== 3'b000 || ls !== 3'b000) begin
                bad++;
                $display("FAIL fault_restart cyc=%0d got hs=%b ls=%b dead=%b exp 000/000/111", i, hs, ls, dead);
            end
        end
        tick();
        total++;
        if (hs !== 3'b111 || dead !== 3'b000) begin
            bad++;
            $display("FAIL fault_resume got hs=%b dead=%b exp 111/000", hs, dead);
        end
    endtask

    task automatic test_disable();
        en = 3'b110;
        tick();
        total++;
        if (hs !== 3'b110 || ls !== 3'b000 || dead !== 3'b000) begin
            bad++;
            $display("FAIL disable got hs=%b ls=%b dead=%b exp 110/000/000", hs, ls, dead);
        end
        en = 3'b111;
        tick();
        total++;
        if (dead !== 3'b001 || hs !== 3'b110) begin
            bad++;
            $display("FAIL reenable got hs=%b dead=%b exp 110/001", hs, dead);
        end
        tick(); tick();
        total++;
        if (hs !== 3'b111 || dead !== 3'b000) begin
            bad++;
            $display("FAIL reenable_on got hs=%b dead=%b exp 111/000", hs, dead);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] phs;
        logic [CH-1:0] pls;
        logic          tgt;
        logic          ok;
        int            d;
        phs = hs;
        pls = ls;
        for (int seg = 0; seg < 8; seg++) begin
            d  = int'($urandom_range(0, 15));
            dt = DW'(d);
            en = CH'($urandom_range(1, 7));
            for (int cyc = 0; cyc < 150; cyc++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 7) == 0) pwm[c] = ~pwm[c];
                tick();
                total++;
                if ((hs & ls) !== 3'b000 || ((hs | ls) & ~en) !== 3'b000) begin
                    bad++;
                    $display("FAIL rnd_overlap seg=%0d cyc=%0d hs=%b ls=%b en=%b", seg, cyc, hs, ls, en);
                end
                if (cyc >= 20) begin
                    for (int c = 0; c < CH; c++) begin
                        if ((hs[c] && !phs[c]) || (ls[c] && !pls[c])) begin
                            tgt = hs[c];
                            ok  = (ph[d+1][c] != tgt);
                            for (int i = 0; i <= d; i++)
                                if (ph[i][c] != tgt) ok = 1'b0;
                            total++;
                            if (!ok) begin
                                bad++;
                                $display("FAIL rnd_gap seg=%0d cyc=%0d ch=%0d side=%b dt=%0d", seg, cyc, c, tgt, d);
                            end
                        end
                    end
                end
                phs = hs;
                pls = ls;
            end
        end
    endtask

    initial begin
        test_reset();
        test_deadtime();
        test_dt0();
        test_glitch();
        test_dt_sample();
        test_fault();
        test_disable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
